// File: rtl/bram_chk_pkg.sv
// Shared types, default widths and the ramp-pattern compare for the BRAM
// read-side checker. The optional halt-on-error behaviour is selected in the
// top level by the BRAM_CHK_HALT_ON_ERR_EN macro.
package bram_chk_pkg;

    // Default geometry of the RAM under test.
    localparam int unsigned DEF_ADDR_W     = 10;
    localparam int unsigned DEF_DATA_W     = 32;
    localparam int unsigned DEF_CNT_W      = 16;
    localparam int unsigned DEF_SKIP_READS = 2048;

    // Widest data word the compare function handles.
    localparam int unsigned MAX_W = 64;

    // State encodings, also visible to the logic analyzer on the state port.
    localparam logic [1:0] ST_SKIP  = 2'd0;
    localparam logic [1:0] ST_CHECK = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;

    typedef enum logic [1:0] {
        StSkip  = ST_SKIP,
        StCheck = ST_CHECK,
        StHalt  = ST_HALT
    } chk_state_e;

    // Returns {up, dn}. Inputs are zero-extended to MAX_W by the caller and
    // addr_w selects how many low bits form the address field. up wins if both
    // forms could ever match, so at most one bit is set.
    function automatic logic [1:0] pattern_match(input logic [MAX_W-1:0] addr,
                                                 input logic [MAX_W-1:0] data,
                                                 input int unsigned      addr_w);
        logic [MAX_W-1:0] mask;
        logic             hi_ok;
        logic             up;
        logic             dn;
        mask  = ~({MAX_W{1'b1}} << addr_w);
        hi_ok = ((data & ~mask) == '0);
        up    = hi_ok && ((data & mask) == (addr & mask));
        dn    = hi_ok && ((data & mask) == (~addr & mask)) && !up;
        return {up, dn};
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and synchronous clear.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Count up on inc, holding at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/bram_pattern_checker.sv
// Read-side monitor for the SDP block RAM test. Registers each read request,
// compares the RAM data returned one cycle later against the writer's up/down
// ramp, and reports pulses, saturating statistics and a first-error capture.
// Define BRAM_CHK_HALT_ON_ERR_EN to freeze everything on the first error.
module bram_pattern_checker
    import bram_chk_pkg::*;
#(
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned DATA_W     = DEF_DATA_W,     // > ADDR_W, <= MAX_W
    parameter int unsigned CNT_W      = DEF_CNT_W,
    parameter int unsigned SKIP_READS = DEF_SKIP_READS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              chk_valid,
    output logic              chk_err,
    output logic              err_sticky,
    output logic [CNT_W-1:0]  rd_count,
    output logic [CNT_W-1:0]  up_count,
    output logic [CNT_W-1:0]  dn_count,
    output logic [CNT_W-1:0]  err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [DATA_W-1:0] first_err_data,
    output logic [1:0]        state
);

    // Request pipeline: rd_data is valid while p_en is high.
    logic              p_en;
    logic [ADDR_W-1:0] p_addr;

    chk_state_e  state_q;
    chk_state_e  state_d;
    logic [31:0] skip_cnt_q;
    logic [31:0] skip_cnt_d;

    logic [1:0] match;
    logic       is_up;
    logic       is_dn;
    logic       is_fail;
    logic       chk_fire;

    assign match   = pattern_match(MAX_W'(p_addr), MAX_W'(rd_data), ADDR_W);
    assign is_up   = match[1];
    assign is_dn   = match[0];
    assign is_fail = !(is_up || is_dn);

    // Register the read request so it lines up with the returned data.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            p_en   <= 1'b0;
            p_addr <= '0;
        end else begin
            p_en   <= rd_en;
            p_addr <= rd_addr;
        end
    end

    // Next-state logic: skip the fill reads, then check every returned word.
    always_comb begin
        state_d    = state_q;
        skip_cnt_d = skip_cnt_q;
        chk_fire   = 1'b0;
        unique case (state_q)
            StSkip: begin
                if (SKIP_READS == 0) begin
                    state_d = StCheck;
                end else if (p_en) begin
                    skip_cnt_d = skip_cnt_q + 32'd1;
                    if (skip_cnt_d == SKIP_READS) begin
                        state_d = StCheck;
                    end
                end
            end
            StCheck: begin
                if (p_en) begin
                    chk_fire = 1'b1;
`ifdef BRAM_CHK_HALT_ON_ERR_EN
                    if (is_fail) begin
                        state_d = StHalt;
                    end
`endif
                end
            end
            StHalt: begin
                // Held until rst or clr.
                state_d = StHalt;
            end
            default: begin
                state_d = StSkip;
            end
        endcase
    end

    // State and skip-count registers; clr behaves exactly like rst.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state_q    <= StSkip;
            skip_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            skip_cnt_q <= skip_cnt_d;
        end
    end

    assign state = state_q;

    // Registered per-word result pulses; an in-flight compare is dropped on clr.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            chk_valid <= 1'b0;
            chk_err   <= 1'b0;
        end else begin
            chk_valid <= chk_fire;
            chk_err   <= chk_fire && is_fail;
        end
    end

    // Sticky error flag and capture of the first failing word.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            err_sticky     <= 1'b0;
            first_err_addr <= '0;
            first_err_data <= '0;
        end else if (chk_fire && is_fail && !err_sticky) begin
            err_sticky     <= 1'b1;
            first_err_addr <= p_addr;
            first_err_data <= rd_data;
        end
    end

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_rd_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .inc   (chk_fire),
        .count (rd_count)
    );

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_up_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .inc   (chk_fire && is_up),
        .count (up_count)
    );

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_dn_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .inc   (chk_fire && is_dn),
        .count (dn_count)
    );

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .inc   (chk_fire && is_fail),
        .count (err_count)
    );

endmodule

// File: tb/tb_bram_pattern_checker.sv
// Scoreboard bench for bram_pattern_checker: reads push expected results into
// a queue, a negedge monitor pops them on every chk_valid pulse.
module tb_bram_pattern_checker;
    import bram_chk_pkg::*;

    localparam int unsigned AW   = 10;
    localparam int unsigned DW   = 32;
    localparam int unsigned CW   = 16;
    localparam int unsigned SKIP = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          clr;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          chk_valid;
    logic          chk_err;
    logic          err_sticky;
    logic [CW-1:0] rd_count;
    logic [CW-1:0] up_count;
    logic [CW-1:0] dn_count;
    logic [CW-1:0] err_count;
    logic [AW-1:0] first_err_addr;
    logic [DW-1:0] first_err_data;
    logic [1:0]    state;

    always #10 clk = ~clk;

    bram_pattern_checker #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .CNT_W      (CW),
        .SKIP_READS (SKIP)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .clr            (clr),
        .rd_en          (rd_en),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data),
        .chk_valid      (chk_valid),
        .chk_err        (chk_err),
        .err_sticky     (err_sticky),
        .rd_count       (rd_count),
        .up_count       (up_count),
        .dn_count       (dn_count),
        .err_count      (err_count),
        .first_err_addr (first_err_addr),
        .first_err_data (first_err_data),
        .state          (state)
    );

    // RAM model: data appears the cycle after the read enable.
    logic [DW-1:0] mem [0:1023];
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    typedef struct packed {
        logic          err;
        logic [1:0]    st;
        logic          sticky;
        logic [CW-1:0] rd;
        logic [CW-1:0] up;
        logic [CW-1:0] dn;
        logic [CW-1:0] ec;
        logic [AW-1:0] fa;
        logic [DW-1:0] fd;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model state.
    logic [1:0]    m_state;
    int            m_skip;
    logic [CW-1:0] m_rd, m_up, m_dn, m_ec;
    logic          m_sticky;
    logic [AW-1:0] m_fa;
    logic [DW-1:0] m_fd;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == {CW{1'b1}}) ? v : v + CW'(1);
    endfunction

    task automatic model_reset();
        m_state  = ST_SKIP;
        m_skip   = 0;
        m_rd     = '0;
        m_up     = '0;
        m_dn     = '0;
        m_ec     = '0;
        m_sticky = 1'b0;
        m_fa     = '0;
        m_fd     = '0;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Issue one read for a cycle and update the model.
    task automatic read_at(input logic [AW-1:0] a);
        logic [DW-1:0] d;
        logic          up;
        logic          dn;
        exp_t          e;
        rd_en   = 1'b1;
        rd_addr = a;
        if (m_state == ST_SKIP) begin
            m_skip++;
            if (m_skip == SKIP) m_state = ST_CHECK;
        end else if (m_state == ST_CHECK) begin
            d    = mem[a];
            up   = (d[DW-1:AW] == '0) && (d[AW-1:0] == a);
            dn   = (d[DW-1:AW] == '0) && (d[AW-1:0] == ~a) && !up;
            m_rd = sat_inc(m_rd);
            if (up) m_up = sat_inc(m_up);
            else if (dn) m_dn = sat_inc(m_dn);
            else begin
                m_ec = sat_inc(m_ec);
                if (!m_sticky) begin
                    m_sticky = 1'b1;
                    m_fa     = a;
                    m_fd     = d;
                end
`ifdef BRAM_CHK_HALT_ON_ERR_EN
                m_state = ST_HALT;
`endif
            end
            e.err    = !(up || dn);
            e.st     = m_state;
            e.sticky = m_sticky;
            e.rd     = m_rd;
            e.up     = m_up;
            e.dn     = m_dn;
            e.ec     = m_ec;
            e.fa     = m_fa;
            e.fd     = m_fd;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rd_en = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_clear();
        rd_en = 1'b0;
        clr   = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        model_reset();
    endtask

    task automatic skip_reads();
        for (int i = 0; i < int'(SKIP); i++) read_at(AW'(100 + i));
    endtask

    // Monitor: every pulse must match the oldest expected entry.
    initial begin
        exp_t e;
        exp_t a;
        forever begin
            @(negedge clk);
            if (chk_valid) begin
                total++;
                a.err    = chk_err;
                a.st     = state;
                a.sticky = err_sticky;
                a.rd     = rd_count;
                a.up     = up_count;
                a.dn     = dn_count;
                a.ec     = err_count;
                a.fa     = first_err_addr;
                a.fd     = first_err_data;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_pulse: chk_err=%0b rd=%0h", chk_err, rd_count);
                end else begin
                    e = exp_q.pop_front();
                    if (a != e) begin
                        bad++;
                        $display("FAIL pulse: got err=%0b st=%0d stk=%0b rd=%0h up=%0h dn=%0h ec=%0h fa=%0h fd=%0h expected err=%0b st=%0d stk=%0b rd=%0h up=%0h dn=%0h ec=%0h fa=%0h fd=%0h",
                                 a.err, a.st, a.sticky, a.rd, a.up, a.dn, a.ec, a.fa, a.fd,
                                 e.err, e.st, e.sticky, e.rd, e.up, e.dn, e.ec, e.fa, e.fd);
                    end
                end
            end else if (chk_err) begin
                total++;
                bad++;
                $display("FAIL err_without_valid: chk_err=1 expected 0");
            end
        end
    end

    initial begin
        rst     = 1'b1;
        clr     = 1'b0;
        rd_en   = 1'b0;
        rd_addr = '0;
        for (int i = 0; i < 1024; i++) mem[i] = DW'(i);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset values.
        check("rst_state", 64'(state), 64'(ST_SKIP));
        check("rst_valid", 64'({chk_valid, chk_err, err_sticky}), 64'd0);
        check("rst_counts", 64'({rd_count, up_count, dn_count, err_count}), 64'd0);
        check("rst_capture", 64'({first_err_addr, first_err_data}), 64'd0);

        // Full sweep of the increment form: 4 skipped, 1020 checked.
        for (int i = 0; i < 1024; i++) read_at(AW'(i));
        idle(3);
        check("sweep_up", 64'(up_count), 64'd1020);
        check("sweep_rd", 64'(rd_count), 64'd1020);
        check("sweep_err", 64'({err_count, err_sticky}), 64'd0);
        check("sweep_state", 64'(state), 64'(ST_CHECK));

        // Decrement form at 0x005.
        mem[5] = 32'h0000_03FA;
        read_at(AW'(5));
        idle(3);
        check("dn_count", 64'(dn_count), 64'd1);
        check("dn_no_err", 64'(err_count), 64'd0);

        // Error at 0x010: pulse exactly two cycles after rd_en.
        mem[16] = 32'h0000_0011;
        read_at(AW'(16));
        rd_en = 1'b0;
        check("err_early", 64'({chk_valid, chk_err}), 64'd0);
        @(posedge clk);
        #1;
        check("err_pulse", 64'({chk_valid, chk_err}), 64'd3);
        check("err_sticky", 64'(err_sticky), 64'd1);
        check("first_addr", 64'(first_err_addr), 64'h010);
        check("first_data", 64'(first_err_data), 64'h0000_0011);
`ifdef BRAM_CHK_HALT_ON_ERR_EN
        check("halt_state", 64'(state), 64'(ST_HALT));
        for (int i = 32; i < 42; i++) read_at(AW'(i));
        idle(3);
        check("halt_state_held", 64'(state), 64'(ST_HALT));
        check("halt_err_count", 64'(err_count), 64'd1);
        check("halt_rd_frozen", 64'(rd_count), 64'd1022);
        do_clear();
        check("clr_state", 64'(state), 64'(ST_SKIP));
        check("clr_outputs", 64'({chk_valid, chk_err, err_sticky, rd_count, up_count,
                                  dn_count}), 64'd0);
        check("clr_capture", 64'({err_count, first_err_addr, first_err_data}), 64'd0);
`else
        check("no_halt_state", 64'(state), 64'(ST_CHECK));
`endif
        idle(2);

        // Upper-bit error, then a second error must not move the capture.
        do_clear();
        skip_reads();
        mem[32] = 32'h0400_0020;
        mem[48] = 32'h0000_0031;
        read_at(AW'(32));
        idle(3);
        check("hi_err_count", 64'(err_count), 64'd1);
        check("hi_first_addr", 64'(first_err_addr), 64'h020);
        read_at(AW'(48));
        idle(3);
        check("second_first_addr", 64'(first_err_addr), 64'h020);
        check("second_first_data", 64'(first_err_data), 64'h0400_0020);
`ifdef BRAM_CHK_HALT_ON_ERR_EN
        check("second_err_count", 64'(err_count), 64'd1);
`else
        check("second_err_count", 64'(err_count), 64'd2);
        read_at(AW'(64));
        idle(3);
        check("keep_checking_rd", 64'(rd_count), 64'd3);
`endif

        // clr right behind a failing read discards it.
        do_clear();
        skip_reads();
        read_at(AW'(48));
        rd_en = 1'b0;
        clr   = 1'b1;
        void'(exp_q.pop_back());
        model_reset();
        @(posedge clk);
        #1;
        clr = 1'b0;
        check("clr_drop_pulse", 64'({chk_valid, chk_err}), 64'd0);
        idle(3);
        check("clr_drop_counts", 64'({err_count, rd_count, err_sticky}), 64'd0);
        check("clr_drop_state", 64'(state), 64'(ST_SKIP));

        // Saturation: more than 65535 checked reads.
        mem[5]  = 32'd5;
        mem[16] = 32'd16;
        mem[32] = 32'd32;
        mem[48] = 32'd48;
        skip_reads();
        for (int i = 0; i < 65540; i++) read_at(AW'(i % 1024));
        idle(3);
        check("sat_rd", 64'(rd_count), 64'hFFFF);
        check("sat_up", 64'(up_count), 64'hFFFF);
        read_at(AW'(7));
        idle(3);
        check("sat_rd_hold", 64'(rd_count), 64'hFFFF);
        check("sat_no_err", 64'(err_count), 64'd0);

        idle(2);
        check("scoreboard_drain", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bram_pattern_checker.md
# bram_pattern_checker

- Self-checking read-side monitor for the SDP block RAM test.
- Sits on the `clk50` read port, downstream of the RAM.
- Takes each read request (address plus enable) and the RAM's unregistered read data one cycle later, and checks every word against the writer's up/down ramp pattern.
- Exposes error flags, counters and a first-error capture, so the logic analyzer needs only the checker outputs.

## Interface

Parameters:
- `ADDR_W`, default 10: RAM address width.
- `DATA_W`, default 32: RAM data width; must be greater than `ADDR_W`.
- `CNT_W`, default 16: width of all statistics counters.
- `SKIP_READS`, default 2048: number of checked reads discarded after reset or `clr`, to cover the RAM fill.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  read-side clock (50 MHz).
- `rst`  in  1  synchronous, active-high reset.
- `clr`  in  1  synchronous clear of counters, capture and state; same effect as `rst`.
- `rd_en`  in  1  RAM read enable issued this cycle (`enb`).
- `rd_addr`  in  `ADDR_W`  RAM read address issued this cycle (`addrb`).
- `rd_data`  in  `DATA_W`  RAM read data (`doutb`), valid one cycle after `rd_en`.
- `chk_valid`  out  1  one-cycle pulse: a word was checked.
- `chk_err`  out  1  one-cycle pulse, coincident with `chk_valid`: that word failed.
- `err_sticky`  out  1  set on the first error; cleared only by `rst`/`clr`.
- `rd_count`  out  `CNT_W`  number of checked words, saturating.
- `up_count`  out  `CNT_W`  words matching the increment form, saturating.
- `dn_count`  out  `CNT_W`  words matching the decrement form, saturating.
- `err_count`  out  `CNT_W`  failed words, saturating.
- `first_err_addr`  out  `ADDR_W`  address of the first failed word.
- `first_err_data`  out  `DATA_W`  data of the first failed word.
- `state`  out  2  current FSM state, for the analyzer.

## Operation

Expected pattern: each word at address `A` holds one of two forms.
- Increment form: `rd_data[ADDR_W-1:0] == A`.
- Decrement form: `rd_data[ADDR_W-1:0] == ~A` (bitwise, `ADDR_W` wide).
- In both forms, `rd_data[DATA_W-1:ADDR_W]` must be 0.
- Either form is legal at any time. The writer is asynchronous, and a read colliding with a write may return the old form; that is not an error.
- If `ADDR_W`-wide `A == ~A` were ever possible, the word counts as up. With `ADDR_W > 0` this never happens.

Pipeline:
- `rd_en` and `rd_addr` are registered once (`p_en`, `p_addr`).
- The compare happens when `p_en == 1`, against the current `rd_data`.
- The compare result is registered, and all outputs update one cycle later.

FSM states (encoding: SKIP=0, CHECK=1, HALT=2):
- SKIP: compares run, but nothing is counted or flagged, and `chk_valid` stays 0. A skip counter increments on each `p_en`; the FSM moves to CHECK on the `p_en` that brings the count to `SKIP_READS`. With `SKIP_READS == 0`, the FSM goes directly to CHECK on the cycle after reset.
- CHECK: every `p_en` produces `chk_valid`.
  - Pass: increment `rd_count`, plus `up_count` or `dn_count`.
  - Fail: increment `rd_count` and `err_count`, and pulse `chk_err`.
  - If `err_sticky` was 0, capture `first_err_addr`/`first_err_data` and set `err_sticky`.
- HALT: reachable only with `BRAM_CHK_HALT_ON_ERR_EN`. All counters and the capture are frozen, and `chk_valid` stays 0. The only exit is `rst` or `clr`, which returns to SKIP.

Boundary conditions:
- Counters saturate at all-ones and never wrap.
- Address wrap from 0x3FF to 0x000 needs no special handling; the check is per address.
- `rst` and `clr` asserted mid-pipeline discard the in-flight compare: no pulse appears on the following cycle.
- `clr` has priority over a simultaneous `p_en`.
- `rd_en` held high on consecutive cycles is legal; one check is made per cycle.

Reset values:
- All counters, `err_sticky`, `chk_valid`, `chk_err`, `first_err_addr`, `first_err_data`, `p_en` and `p_addr` are 0.
- `state` is SKIP.

## Timing

- `rd_en` in cycle N → `rd_data` sampled in N+1 → `chk_valid`/`chk_err` and counter updates visible in N+2.
- Throughput: one check per cycle.
- `err_sticky` and the first-error capture become visible in the same cycle as the first `chk_err`.
- With HALT compiled in, `state == HALT` is visible in the same cycle as that first `chk_err`.

## Configuration

- `BRAM_CHK_HALT_ON_ERR_EN` defined: the first error in CHECK moves the FSM to HALT. The error is still counted (`err_count == 1`), and all state is then frozen until `rst` or `clr`.
- Not defined: HALT is unreachable. The checker keeps checking after errors, and `err_count` accumulates.

## Structure

- Package `bram_chk_pkg` holds:
  - the state enum and its encoding constants (SKIP, CHECK, HALT);
  - the default widths and `SKIP_READS` constant;
  - a function `pattern_match(addr, data)` returning {up, dn}.
- One sub-module, `sat_counter` (width parameter, `inc`, `clr`), instantiated four times.

## Test plan

- Fill the RAM model with the increment form, use `SKIP_READS=4`, and read addresses 0..1023 continuously. Require:
  - `up_count == 1020` after the last check;
  - `err_count == 0`, `err_sticky == 0`.
- Read address 0x005 holding 0x0000_03FA after SKIP. Require `dn_count` +1 and no `chk_err`.
- Read address 0x010 holding 0x0000_0011 in CHECK. Require:
  - `chk_err` pulse two cycles after `rd_en`;
  - `first_err_addr == 0x010`, `first_err_data == 0x0000_0011`.
- Read address 0x020 holding 0x0400_0020 (upper bit set). Require an error. Then a second error at 0x030 must leave the first-error capture unchanged at 0x020.
- Force `rd_count` to 0xFFFF and perform one more read. Require it to stay at 0xFFFF.
- With `BRAM_CHK_HALT_ON_ERR_EN`, inject one error and then 10 good reads. Require:
  - `state == HALT`, `err_count == 1`, `rd_count` frozen;
  - after `clr`, all outputs are 0 and `state == SKIP`.
